mem_responder: RTL and testbench

Memory-side responder for the datapath's MAR/MDR memory interface. Accepts a read or write request (address from MAR, write data from MDR), holds it for a fixed number of wait states, then performs the access against an internal word-addressed RAM. For reads it returns the word on `Mdatain` with a one-cycle `done` strobe, which the control unit uses to load MDR through its memory-select path.

---
 rtl/mem_responder.sv | 67 ++++++
 tb/tb_mem_responder.sv | 118 +++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: wait-stated RAM responder for MAR/MDR (clk, clr, read, write, address, data_in -> Mdatain, done, busy)
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  done,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic op_rd;
  logic fire;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  assign fire = (state == WAIT) && (cnt == 4'd0);
  always_ff @(posedge clk)
    if (!clr && fire && !op_rd) mem[addr_q] <= data_q;
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      Mdatain <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      op_rd   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (read || write) begin
            addr_q <= address;
            data_q <= data_in;
            op_rd  <= read;
            cnt    <= 4'(WAIT_STATES);
            busy   <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (fire) begin
            state <= RESP;
            done  <= 1'b1;
            if (op_rd) Mdatain <= mem[addr_q];
          end else cnt <= cnt - 4'd1;
        end
        RESP: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder with WAIT_STATES 2 and 0
module tb_mem_responder;
  logic clk = 1'b0, clr = 1'b0;
  logic read = 1'b0, write = 1'b0;
  logic [8:0] address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] q;
  logic done, busy;
  logic r0 = 1'b0, w0 = 1'b0;
  logic [8:0] a0 = '0;
  logic [31:0] d0 = '0;
  logic [31:0] q0;
  logic done0, busy0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(2)) dut (
    .clk(clk), .clr(clr), .read(read), .write(write), .address(address),
    .data_in(data_in), .Mdatain(q), .done(done), .busy(busy)
  );
  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .clr(clr), .read(r0), .write(w0), .address(a0),
    .data_in(d0), .Mdatain(q0), .done(done0), .busy(busy0)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input bit sel, input logic rd, input logic wr, input logic [8:0] a,
                    input logic [31:0] d, input bit disturb, input int exp_lat,
                    input logic [31:0] exp_q, input string tag);
    int lat, nd;
    logic [31:0] qd;
    if (sel) begin r0 = rd; w0 = wr; a0 = a; d0 = d; end
    else begin read = rd; write = wr; address = a; data_in = d; end
    step();
    chk({tag, " busy_accept"}, 32'(sel ? busy0 : busy), 32'd1);
    if (sel) begin r0 = 1'b0; w0 = 1'b0; end
    else if (disturb) begin read = 1'b0; write = 1'b1; address = 9'h020; data_in = 32'hFFFF_FFFF; end
    else begin read = 1'b0; write = 1'b0; end
    lat = -1;
    nd = 0;
    qd = '0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (!sel && disturb && i == 1) begin write = 1'b0; address = '0; data_in = '0; end
      if (sel ? done0 : done) begin
        nd++;
        if (lat < 0) begin lat = i; qd = sel ? q0 : q; end
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " done_count"}, 32'(nd), 32'd1);
    chk({tag, " data_at_done"}, qd, exp_q);
    chk({tag, " data_after"}, sel ? q0 : q, exp_q);
    chk({tag, " busy_end"}, 32'(sel ? busy0 : busy), 32'd0);
  endtask
  initial begin
    clr = 1'b1;
    read = 1'b1;
    step();
    chk("rst1 q", q, 32'd0);
    chk("rst1 done", 32'(done), 32'd0);
    chk("rst1 busy", 32'(busy), 32'd0);
    step();
    chk("rst2 q", q, 32'd0);
    chk("rst2 done", 32'(done), 32'd0);
    chk("rst2 busy", 32'(busy), 32'd0);
    clr = 1'b0;
    read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst done", 32'(done), 32'd0);
      chk("post_rst busy", 32'(busy), 32'd0);
    end
    op(0, 0, 1, 9'h005, 32'hDEAD_BEEF, 0, 3, 32'h0, "wr005");
    op(0, 1, 0, 9'h005, 32'h0, 0, 3, 32'hDEAD_BEEF, "rd005");
    op(1, 0, 1, 9'h1FF, 32'h1234_5678, 0, 1, 32'h0, "w0_wr1ff");
    op(1, 0, 1, 9'h000, 32'h0000_BBBB, 0, 1, 32'h0, "w0_wr000");
    op(1, 1, 0, 9'h1FF, 32'h0, 0, 1, 32'h1234_5678, "w0_rd1ff");
    op(1, 1, 0, 9'h000, 32'h0, 0, 1, 32'h0000_BBBB, "w0_rd000");
    op(0, 0, 1, 9'h010, 32'hAAAA_5555, 0, 3, 32'hDEAD_BEEF, "wr010");
    op(0, 1, 1, 9'h010, 32'h0, 0, 3, 32'hAAAA_5555, "rdwr010");
    op(0, 1, 0, 9'h010, 32'h0, 0, 3, 32'hAAAA_5555, "rd010");
    op(0, 0, 1, 9'h020, 32'h0000_0077, 0, 3, 32'hAAAA_5555, "wr020");
    op(0, 1, 0, 9'h005, 32'h0, 1, 3, 32'hDEAD_BEEF, "rd005_disturb");
    op(0, 1, 0, 9'h020, 32'h0, 0, 3, 32'h0000_0077, "rd020");
    op(0, 0, 1, 9'h030, 32'h0000_0001, 0, 3, 32'h0000_0077, "wr030");
    write = 1'b1;
    address = 9'h030;
    data_in = 32'hCAFE_F00D;
    step();
    write = 1'b0;
    address = '0;
    data_in = '0;
    step();
    step();
    clr = 1'b1;
    step();
    chk("clr_mid done", 32'(done), 32'd0);
    chk("clr_mid busy", 32'(busy), 32'd0);
    chk("clr_mid q", q, 32'd0);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("clr_mid post done", 32'(done), 32'd0);
    end
    op(0, 1, 0, 9'h030, 32'h0, 0, 3, 32'h0000_0001, "rd030");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
